// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter driving the single LC-3 register-file write port.
// Optional condition-code update is enabled by defining RF_WB_CC_UPDATE_EN.
module rf_wb_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 16,
    parameter int AW   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_dr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 rf_stall,
    output logic                 ld_reg,
    output logic [AW-1:0]        dr_sel,
    output logic [DW-1:0]        wr_data,
    output logic [1:0]           grant_id,
    output logic [2:0]           nzp,
    output logic                 ld_cc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t            state_r;
    logic [1:0]        rr_ptr_r;
    logic              ld_reg_r;
    logic [AW-1:0]     dr_sel_r;
    logic [DW-1:0]     wr_data_r;
    logic [1:0]        grant_id_r;

    logic [NREQ-1:0]   win_s;
    logic [1:0]        win_idx_s;
    logic              found_s;
    logic              accept_s;
    logic [1:0]        next_ptr_s;
    logic [AW-1:0]     sel_dr_s;
    logic [DW-1:0]     sel_data_s;

    // Winner is the valid requester at the smallest circular distance from rr_ptr.
    always_comb begin
        int best_v;
        int dist_v;
        win_idx_s = 2'd0;
        found_s   = 1'b0;
        best_v    = NREQ;
        dist_v    = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (i >= int'(rr_ptr_r)) begin
                dist_v = i - int'(rr_ptr_r);
            end else begin
                dist_v = i + NREQ - int'(rr_ptr_r);
            end
            if (req_valid[i] && (dist_v < best_v)) begin
                best_v    = dist_v;
                win_idx_s = 2'(i);
                found_s   = 1'b1;
            end else begin
                best_v    = best_v;
            end
        end
    end

    // One-hot winner vector derived from the selected index.
    always_comb begin
        win_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_s[i] = found_s && (win_idx_s == 2'(i));
        end
    end

    assign req_ready  = win_s & {NREQ{~rf_stall & rst_n}};
    assign accept_s   = |req_ready;
    assign next_ptr_s = (win_idx_s == 2'(NREQ - 1)) ? 2'd0 : (win_idx_s + 2'd1);
    assign sel_dr_s   = req_dr[int'(win_idx_s)*AW +: AW];
    assign sel_data_s = req_data[int'(win_idx_s)*DW +: DW];

    // Write-port FSM and registered write outputs; a stall blocks new accepts only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= 2'd0;
            ld_reg_r   <= 1'b0;
            dr_sel_r   <= {AW{1'b0}};
            wr_data_r  <= {DW{1'b0}};
            grant_id_r <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_WRITE, ST_STALL: begin
                    if (rf_stall) begin
                        state_r <= ST_STALL;
                    end else if (accept_s) begin
                        state_r <= ST_WRITE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
            ld_reg_r <= accept_s;
            if (accept_s) begin
                dr_sel_r   <= sel_dr_s;
                wr_data_r  <= sel_data_s;
                grant_id_r <= win_idx_s;
                rr_ptr_r   <= next_ptr_s;
            end
        end
    end

    assign ld_reg   = ld_reg_r;
    assign dr_sel   = dr_sel_r;
    assign wr_data  = wr_data_r;
    assign grant_id = grant_id_r;

`ifdef RF_WB_CC_UPDATE_EN
    logic [2:0] nzp_r;
    logic       ld_cc_r;

    function automatic logic [2:0] cc_of(input logic [DW-1:0] d);
        logic is_zero;
        is_zero = (d == {DW{1'b0}});
        return {d[DW-1], is_zero, ~d[DW-1] & ~is_zero};
    endfunction

    // Condition codes follow the accepted data and strobe together with ld_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzp_r   <= 3'b000;
            ld_cc_r <= 1'b0;
        end else begin
            ld_cc_r <= accept_s;
            if (accept_s) begin
                nzp_r <= cc_of(sel_data_s);
            end
        end
    end

    assign nzp   = nzp_r;
    assign ld_cc = ld_cc_r;
`else
    assign nzp   = 3'b000;
    assign ld_cc = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: predicts grants per cycle, queues expected writes,
// and compares them against each ld_reg strobe.
module tb_rf_wb_arbiter;
    localparam int NREQ = 2;
    localparam int DW   = 16;
    localparam int AW   = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*AW-1:0]  req_dr;
    logic [NREQ*DW-1:0]  req_data;
    logic                rf_stall;
    logic                ld_reg;
    logic [AW-1:0]       dr_sel;
    logic [DW-1:0]       wr_data;
    logic [1:0]          grant_id;
    logic [2:0]          nzp;
    logic                ld_cc;

    typedef struct packed {
        logic [AW-1:0] dr;
        logic [DW-1:0] data;
        logic [1:0]    id;
    } exp_t;

    exp_t            sb_q[$];
    int              n_checks = 0;
    int              n_errors = 0;
    int              rr_m = 0;
    bit              pending_m = 1'b0;
    logic [2:0]      nzp_m = 3'b000;
    logic [NREQ-1:0] last_ready_m = '0;
    logic [DW-1:0]   rf_m [8];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_dr(req_dr), .req_data(req_data), .rf_stall(rf_stall), .ld_reg(ld_reg),
        .dr_sel(dr_sel), .wr_data(wr_data), .grant_id(grant_id), .nzp(nzp), .ld_cc(ld_cc)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_cc(input logic [DW-1:0] d);
`ifdef RF_WB_CC_UPDATE_EN
        if (d[DW-1]) return 3'b100;
        else if (d == 16'h0000) return 3'b010;
        else return 3'b001;
`else
        return 3'b000;
`endif
    endfunction

    // One clock: check last cycle's registered write, predict this cycle's grant.
    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        exp_t e;
        int   w;
        @(negedge clk);
        check_val("ld_reg", 32'(ld_reg), 32'(pending_m));
`ifdef RF_WB_CC_UPDATE_EN
        check_val("ld_cc", 32'(ld_cc), 32'(pending_m));
`else
        check_val("ld_cc", 32'(ld_cc), 32'd0);
`endif
        if (pending_m) begin
            check_val("sb_level", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_val("dr_sel", 32'(dr_sel), 32'(e.dr));
                check_val("wr_data", 32'(wr_data), 32'(e.data));
                check_val("grant_id", 32'(grant_id), 32'(e.id));
                nzp_m = exp_cc(e.data);
            end
        end
        check_val("nzp", 32'(nzp), 32'(nzp_m));
        if (ld_reg) rf_m[dr_sel] = wr_data;
        exp_ready = '0;
        w = -1;
        if (!rf_stall) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (rr_m + k) % NREQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        if (w >= 0) begin
            exp_ready[w] = 1'b1;
            e.dr   = req_dr[w*AW +: AW];
            e.data = req_data[w*DW +: DW];
            e.id   = 2'(w);
            sb_q.push_back(e);
            rr_m = (w + 1) % NREQ;
        end
        check_val("req_ready", 32'(req_ready), 32'(exp_ready));
        pending_m    = (w >= 0);
        last_ready_m = exp_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] dr, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_dr[i*AW +: AW]   = dr;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_dr    = '0;
        req_data  = '0;
        rf_stall  = 1'b0;
        for (int r = 0; r < 8; r++) rf_m[r] = 16'h0000;

        // Reset state, with a request present to show ready stays low in reset.
        #12;
        set_req(0, 1'b1, 3'd2, 16'h0F0F);
        #1;
        check_val("rst_ld_reg", 32'(ld_reg), 32'd0);
        check_val("rst_dr_sel", 32'(dr_sel), 32'd0);
        check_val("rst_wr_data", 32'(wr_data), 32'd0);
        check_val("rst_grant_id", 32'(grant_id), 32'd0);
        check_val("rst_nzp", 32'(nzp), 32'd0);
        check_val("rst_ld_cc", 32'(ld_cc), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();

        // Single requester 0.
        set_req(0, 1'b1, 3'd5, 16'h1234);
        cycle();
        req_valid = '0;
        cycle();
        cycle();

        // Same-DR collision with rr_ptr at 1: 5555 then AAAA lands in R3.
        set_req(0, 1'b1, 3'd3, 16'hAAAA);
        set_req(1, 1'b1, 3'd3, 16'h5555);
        cycle();
        req_valid[1] = 1'b0;
        cycle();
        req_valid = '0;
        cycle();
        check_val("collision_r3", 32'(rf_m[3]), 32'h0000AAAA);
        cycle();

        // Stall for three cycles, then accept right after release.
        set_req(0, 1'b1, 3'd6, 16'h7777);
        rf_stall = 1'b1;
        repeat (3) cycle();
        rf_stall = 1'b0;
        cycle();
        req_valid = '0;
        cycle();
        cycle();

        // Reset in the middle of a write strobe.
        set_req(0, 1'b1, 3'd4, 16'hBEEF);
        cycle();
        check_val("pre_rst_ld_reg", 32'(ld_reg), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_ld_reg", 32'(ld_reg), 32'd0);
        check_val("midrst_dr_sel", 32'(dr_sel), 32'd0);
        check_val("midrst_wr_data", 32'(wr_data), 32'd0);
        check_val("midrst_ready", 32'(req_ready), 32'd0);
        sb_q.delete();
        pending_m = 1'b0;
        rr_m      = 0;
        nzp_m     = 3'b000;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round robin from rr_ptr 0: grants 0,1,0,1 with back-to-back strobes.
        set_req(0, 1'b1, 3'd1, 16'h1111);
        set_req(1, 1'b1, 3'd2, 16'h2222);
        repeat (4) cycle();
        req_valid = '0;
        cycle();
        cycle();

        // Condition-code patterns from a single requester on consecutive cycles.
        set_req(0, 1'b1, 3'd7, 16'h8000);
        cycle();
        set_req(0, 1'b1, 3'd7, 16'h0000);
        cycle();
        set_req(0, 1'b1, 3'd7, 16'h0001);
        cycle();
        req_valid = '0;
        cycle();
        cycle();

        // Random traffic honouring the hold-while-not-ready rule.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_ready_m[i]) begin
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
                end
            end
            rf_stall = ($urandom_range(0, 7) == 0);
            cycle();
        end
        req_valid = '0;
        rf_stall  = 1'b0;
        cycle();
        cycle();
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
